// File: rtl/noc_alloc_pkg.sv
// Shared types and constants for the router output-port allocator.
package noc_alloc_pkg;

  // Input port indices in N,S,W,E,L order.
  localparam int unsigned PORT_N = 0;
  localparam int unsigned PORT_S = 1;
  localparam int unsigned PORT_W = 2;
  localparam int unsigned PORT_E = 3;
  localparam int unsigned PORT_L = 4;

  localparam int unsigned FLIT_W = 16;
  localparam int unsigned LEN_W  = 4;
  // Crossbar select / owner index width.
  localparam int unsigned SEL_W  = 3;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    XFER = 1'b1
  } alloc_state_t;

  // Body flit count carried in the low bits of a header flit.
  function automatic logic [LEN_W-1:0] flit_len(input logic [FLIT_W-1:0] flit);
    return flit[LEN_W-1:0];
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first eligible index at or after rr_ptr_i.
module rr_pick #(
  parameter int unsigned NUM_IN = 5,
  parameter int unsigned IDX_W  = 3
) (
  input  logic [NUM_IN-1:0] eligible_i,
  input  logic [IDX_W-1:0]  rr_ptr_i,
  output logic [IDX_W-1:0]  winner_o,
  output logic              any_o
);

  logic [IDX_W:0] idx;

  // Scan rr_ptr_i, rr_ptr_i+1, ... wrapping at NUM_IN; the first hit wins.
  always_comb begin
    winner_o = '0;
    any_o    = 1'b0;
    idx      = '0;
    for (int unsigned k = 0; k < NUM_IN; k++) begin
      idx = {1'b0, rr_ptr_i} + (IDX_W+1)'(k);
      if (idx >= (IDX_W+1)'(NUM_IN)) begin
        idx = idx - (IDX_W+1)'(NUM_IN);
      end
      if (!any_o && eligible_i[idx[IDX_W-1:0]]) begin
        any_o    = 1'b1;
        winner_o = idx[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/output_port_allocator.sv
// Wormhole switch allocator for one router output port.
// Round-robin arbitration among inputs whose head flit targets this port; the
// winner holds the port until its whole packet (header + body) has crossed.
// Optional: define OUTPUT_PORT_ALLOCATOR_STALL_CNT_EN to add stall_cnt_o, a
// saturating count of locked cycles in which no flit moved.
module output_port_allocator #(
  parameter int unsigned NUM_IN = 5,
  parameter int unsigned FLIT_W = 16,
  parameter int unsigned LEN_W  = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_IN-1:0]        req_i,
  input  logic [NUM_IN-1:0]        empty_i,
  input  logic [NUM_IN*FLIT_W-1:0] head_flit_i,
  input  logic                     credit_i,
  output logic [NUM_IN-1:0]        read_o,
  output logic [2:0]               sel_o,
  output logic                     flit_valid_o,
  output logic                     cc_dec_o,
  output logic                     busy_o
`ifdef OUTPUT_PORT_ALLOCATOR_STALL_CNT_EN
  ,
  output logic [15:0]              stall_cnt_o
`endif
);

  import noc_alloc_pkg::*;

  localparam int unsigned REM_W = LEN_W + 1;

  alloc_state_t     state_q, state_d;
  logic [SEL_W-1:0] owner_q, owner_d;
  logic [REM_W-1:0] rem_q, rem_d;
  logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;

  logic [NUM_IN-1:0]            eligible;
  logic [SEL_W-1:0]             winner;
  logic                         any_elig;
  logic [NUM_IN-1:0][LEN_W-1:0] len_all;
  logic                         read_any;

  // Extract the length field of every head flit; upper flit bits are payload.
  for (genvar i = 0; i < NUM_IN; i++) begin : g_len
    logic unused_hi;
    assign len_all[i] = head_flit_i[i*FLIT_W +: LEN_W];
    assign unused_hi  = ^head_flit_i[i*FLIT_W+LEN_W +: FLIT_W-LEN_W];
  end

  assign eligible = req_i & ~empty_i;

  rr_pick #(
    .NUM_IN (NUM_IN),
    .IDX_W  (SEL_W)
  ) u_rr_pick (
    .eligible_i (eligible),
    .rr_ptr_i   (rr_ptr_q),
    .winner_o   (winner),
    .any_o      (any_elig)
  );

  // A flit moves only while locked, with downstream credit and owner data.
  assign read_any = (state_q == XFER) && credit_i && !empty_i[owner_q];

  // State, owner, remaining-flit count and round-robin pointer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      owner_q  <= '0;
      rem_q    <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rem_q    <= rem_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  // Next state: grant in IDLE, count flits down in XFER.
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    rem_d    = rem_q;
    rr_ptr_d = rr_ptr_q;
    unique case (state_q)
      IDLE: begin
        if (any_elig) begin
          state_d  = XFER;
          owner_d  = winner;
          // Header plus body flits; a zero-length header is a single flit.
          rem_d    = {1'b0, len_all[winner]} + REM_W'(1);
          rr_ptr_d = (winner == SEL_W'(NUM_IN - 1)) ? '0 : winner + SEL_W'(1);
        end
      end
      XFER: begin
        if (read_any) begin
          rem_d = rem_q - REM_W'(1);
          if (rem_q == REM_W'(1)) begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs: read strobe to the owner only; select and busy come from registers.
  always_comb begin
    read_o = '0;
    if (read_any) begin
      read_o[owner_q] = 1'b1;
    end
    flit_valid_o = read_any;
    cc_dec_o     = read_any;
    sel_o        = owner_q;
    busy_o       = (state_q == XFER);
  end

`ifdef OUTPUT_PORT_ALLOCATOR_STALL_CNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  // Saturating count of locked cycles that moved no flit.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if ((state_q == XFER) && !read_any && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  // Stall counter register; cleared only by reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_output_port_allocator.sv
// Directed bench for output_port_allocator with a queue-based scoreboard.
module tb_output_port_allocator;

  localparam int unsigned NUM_IN = 5;
  localparam int unsigned FLIT_W = 16;
  localparam int unsigned LEN_W  = 4;

  logic                     clk;
  logic                     reset;
  logic [NUM_IN-1:0]        req_i;
  logic [NUM_IN-1:0]        empty_i;
  logic [NUM_IN*FLIT_W-1:0] head_flit_i;
  logic                     credit_i;
  logic [NUM_IN-1:0]        read_o;
  logic [2:0]               sel_o;
  logic                     flit_valid_o;
  logic                     cc_dec_o;
  logic                     busy_o;
`ifdef OUTPUT_PORT_ALLOCATOR_STALL_CNT_EN
  logic [15:0]              stall_cnt_o;
`endif

  logic [FLIT_W-1:0] hf [NUM_IN];
  assign head_flit_i = {hf[4], hf[3], hf[2], hf[1], hf[0]};

  output_port_allocator #(
    .NUM_IN (NUM_IN),
    .FLIT_W (FLIT_W),
    .LEN_W  (LEN_W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .req_i        (req_i),
    .empty_i      (empty_i),
    .head_flit_i  (head_flit_i),
    .credit_i     (credit_i),
    .read_o       (read_o),
    .sel_o        (sel_o),
    .flit_valid_o (flit_valid_o),
    .cc_dec_o     (cc_dec_o),
    .busy_o       (busy_o)
`ifdef OUTPUT_PORT_ALLOCATOR_STALL_CNT_EN
    ,
    .stall_cnt_o  (stall_cnt_o)
`endif
  );

  int n_vec  = 0;
  int n_miss = 0;

  // Expected flit transfers: {read_o[4:0], sel_o[2:0]}.
  logic [7:0] exp_q [$];
  logic [7:0] mon_e;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input int unsigned port, input int unsigned n);
    logic [4:0] oh;
    oh = 5'b00001 << port;
    for (int k = 0; k < int'(n); k++) begin
      exp_q.push_back({oh, 3'(port)});
    end
  endtask

  // Monitor: every transfer seen on the falling edge must match the queue head.
  always @(negedge clk) begin
    if (flit_valid_o) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_miss++;
        $display("FAIL unexpected_read: got read_o=%b sel_o=%0d, expected no transfer at %0t",
                 read_o, sel_o, $time);
      end else begin
        mon_e = exp_q.pop_front();
        chk("mon_read_o", 32'(read_o), 32'(mon_e[7:3]));
        chk("mon_sel_o", 32'(sel_o), 32'(mon_e[2:0]));
        chk("mon_cc_dec_o", 32'(cc_dec_o), 32'd1);
      end
    end
  end

  initial begin
    reset    = 1'b0;
    req_i    = 5'b11111;
    empty_i  = 5'b00000;
    credit_i = 1'b1;
    hf[0]    = 16'h1230;
    hf[1]    = 16'hFFF0;
    hf[2]    = 16'h5552;
    hf[3]    = 16'h7773;
    hf[4]    = 16'hABC3;

    // 1: reset holds every output low even with all inputs requesting.
    step();
    step();
    chk("rst_read_o", 32'(read_o), 32'd0);
    chk("rst_sel_o", 32'(sel_o), 32'd0);
    chk("rst_flit_valid_o", 32'(flit_valid_o), 32'd0);
    chk("rst_cc_dec_o", 32'(cc_dec_o), 32'd0);
    chk("rst_busy_o", 32'(busy_o), 32'd0);
`ifdef OUTPUT_PORT_ALLOCATOR_STALL_CNT_EN
    chk("rst_stall_cnt", 32'(stall_cnt_o), 32'd0);
`endif
    reset = 1'b1;
    #1;
    chk("rel_busy_o", 32'(busy_o), 32'd0);
    chk("rel_read_o", 32'(read_o), 32'd0);
    req_i = 5'b00000;
    step();

    // 2: L input, len 3 -> four reads, then IDLE.
    req_i = 5'b10000;
    push_exp(4, 4);
    step();
    chk("t2_busy", 32'(busy_o), 32'd1);
    chk("t2_sel", 32'(sel_o), 32'd4);
    req_i = 5'b00000;
    for (int k = 0; k < 4; k++) step();
    chk("t2_idle", 32'(busy_o), 32'd0);

    // 3: inputs 0 and 1 with single-flit packets alternate with a bubble between.
    req_i = 5'b00011;
    push_exp(0, 1);
    push_exp(1, 1);
    push_exp(0, 1);
    push_exp(1, 1);
    for (int k = 0; k < 8; k++) begin
      step();
      chk("t3_busy_pattern", 32'(busy_o), ((k % 2) == 0) ? 32'd1 : 32'd0);
    end
    req_i = 5'b00000;

    // 4: input 2, len 2; credit withdrawn for three cycles after the first read.
    req_i = 5'b00100;
    push_exp(2, 3);
    step();
    req_i = 5'b00000;
    step();
    credit_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("t4_stall_read", 32'(read_o), 32'd0);
      chk("t4_stall_sel", 32'(sel_o), 32'd2);
      chk("t4_stall_busy", 32'(busy_o), 32'd1);
      step();
    end
    credit_i = 1'b1;
    step();
    step();
    chk("t4_idle", 32'(busy_o), 32'd0);

    // 5: input 3, len 3; owner empty for two cycles while input 0 requests.
    req_i = 5'b01000;
    push_exp(3, 4);
    step();
    req_i = 5'b00001;
    step();
    empty_i = 5'b01000;
    for (int k = 0; k < 2; k++) begin
      #1;
      chk("t5_empty_read", 32'(read_o), 32'd0);
      chk("t5_empty_sel", 32'(sel_o), 32'd3);
      chk("t5_empty_busy", 32'(busy_o), 32'd1);
      step();
    end
    empty_i = 5'b00000;
    for (int k = 0; k < 3; k++) step();
    chk("t5_idle", 32'(busy_o), 32'd0);
    req_i = 5'b00000;
`ifdef OUTPUT_PORT_ALLOCATOR_STALL_CNT_EN
    chk("t5_stall_cnt", 32'(stall_cnt_o), 32'd5);
`endif

    // 6: input 1, len 7; reset after two of eight flits.
    hf[1] = 16'h4447;
    req_i = 5'b00010;
    push_exp(1, 2);
    step();
    chk("t6_sel", 32'(sel_o), 32'd1);
    req_i = 5'b00000;
    step();
    step();
    reset = 1'b0;
    #1;
    chk("t6_rst_busy", 32'(busy_o), 32'd0);
    chk("t6_rst_read", 32'(read_o), 32'd0);
    chk("t6_rst_sel", 32'(sel_o), 32'd0);
`ifdef OUTPUT_PORT_ALLOCATOR_STALL_CNT_EN
    chk("t6_rst_stall_cnt", 32'(stall_cnt_o), 32'd0);
`endif
    step();
    reset = 1'b1;
    // Pointer back at 0: with inputs 0 and 2 requesting, input 0 must win.
    req_i = 5'b00101;
    push_exp(0, 1);
    step();
    chk("t6_rr_sel", 32'(sel_o), 32'd0);
    chk("t6_rr_busy", 32'(busy_o), 32'd1);
    req_i = 5'b00000;
    step();
    chk("t6_idle", 32'(busy_o), 32'd0);

    step();
    chk("pending_transfers", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
